// File: rtl/cache_ctrl_pkg.sv
// Shared state encoding and default widths for the cache refill controller.
package cache_ctrl_pkg;

    localparam int unsigned ADDR_WIDTH_DEF  = 16;
    localparam int unsigned DATA_WIDTH_DEF  = 32;
    localparam int unsigned STATS_WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_RD,
        FILL,
        MEM_WR,
        RESP
    } ctrl_state_t;

endpackage

// File: rtl/cache_ctrl_stats.sv
// Saturating read hit/miss counters; only built when CACHE_CTRL_STATS_EN is defined.
`ifdef CACHE_CTRL_STATS_EN
module cache_ctrl_stats #(
    parameter int unsigned STATS_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hit_inc,
    input  logic                   miss_inc,
    output logic [STATS_WIDTH-1:0] hit_count,
    output logic [STATS_WIDTH-1:0] miss_count
);

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_inc && (hit_count != '1)) begin
                hit_count <= hit_count + STATS_WIDTH'(1);
            end
            if (miss_inc && (miss_count != '1)) begin
                miss_count <= miss_count + STATS_WIDTH'(1);
            end
        end
    end

endmodule
`endif

// File: rtl/cache_refill_ctrl.sv
// Write-through / write-allocate refill controller for a direct-mapped single-word-line cache.
// Optional read hit/miss statistics enabled by defining CACHE_CTRL_STATS_EN.
module cache_refill_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
`ifdef CACHE_CTRL_STATS_EN
    ,
    parameter int unsigned STATS_WIDTH = STATS_WIDTH_DEF
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_req_we,
    input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
    input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
    output logic                  cpu_resp_valid,
    output logic [DATA_WIDTH-1:0] cpu_resp_rdata,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [DATA_WIDTH-1:0] cache_wdata,
    output logic                  cache_write,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    input  logic                  cache_hit,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [STATS_WIDTH-1:0] hit_count,
    output logic [STATS_WIDTH-1:0] miss_count
`endif
);

    ctrl_state_t           state;
    ctrl_state_t           state_nxt;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rdata_ld;
    logic [DATA_WIDTH-1:0] rdata_nxt;
    logic                  accept;

    assign accept     = cpu_req_valid && cpu_req_ready;
    assign cache_addr = addr_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

    // State and request/response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q    <= cpu_req_we;
                addr_q  <= cpu_req_addr;
                wdata_q <= cpu_req_wdata;
            end
            if (rdata_ld) begin
                rdata_q <= rdata_nxt;
            end
        end
    end

    // Next state and state-decoded outputs; mem_ack only matters in the memory states.
    always_comb begin
        state_nxt      = state;
        cpu_req_ready  = 1'b0;
        cpu_resp_valid = 1'b0;
        cpu_resp_rdata = '0;
        cache_write    = 1'b0;
        cache_wdata    = '0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        rdata_ld       = 1'b0;
        rdata_nxt      = '0;
        unique case (state)
            IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) begin
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                if (we_q) begin
                    cache_write = 1'b1;
                    cache_wdata = wdata_q;
                    state_nxt   = MEM_WR;
                end else if (cache_hit) begin
                    rdata_ld  = 1'b1;
                    rdata_nxt = cache_rdata;
                    state_nxt = RESP;
                end else begin
                    state_nxt = MEM_RD;
                end
            end
            MEM_RD: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    rdata_ld  = 1'b1;
                    rdata_nxt = mem_rdata;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                cache_write = 1'b1;
                cache_wdata = rdata_q;
                state_nxt   = RESP;
            end
            MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) begin
                    rdata_ld  = 1'b1;
                    rdata_nxt = '0;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                cpu_resp_valid = 1'b1;
                cpu_resp_rdata = rdata_q;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef CACHE_CTRL_STATS_EN
    logic lookup_rd;
    assign lookup_rd = (state == LOOKUP) && !we_q;

    cache_ctrl_stats #(
        .STATS_WIDTH(STATS_WIDTH)
    ) u_stats (
        .clk       (clk),
        .rst_n     (rst_n),
        .hit_inc   (lookup_rd && cache_hit),
        .miss_inc  (lookup_rd && !cache_hit),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: emulates cache and memory, checks against a transaction-level model.
module tb_cache_refill_ctrl;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
`ifdef CACHE_CTRL_STATS_EN
    localparam int unsigned SW = 2;
    logic [SW-1:0] hit_count;
    logic [SW-1:0] miss_count;
`endif

    logic          clk;
    logic          rst_n;
    logic          cpu_req_valid;
    logic          cpu_req_ready;
    logic          cpu_req_we;
    logic [AW-1:0] cpu_req_addr;
    logic [DW-1:0] cpu_req_wdata;
    logic          cpu_resp_valid;
    logic [DW-1:0] cpu_resp_rdata;
    logic [AW-1:0] cache_addr;
    logic [DW-1:0] cache_wdata;
    logic          cache_write;
    logic [DW-1:0] cache_rdata;
    logic          cache_hit;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    // Emulated external cache RAM (written by the DUT) and the reference model's view.
    logic          emu_v   [16];
    logic [11:0]   emu_tag [16];
    logic [DW-1:0] emu_d   [16];
    logic          ref_v   [16];
    logic [11:0]   ref_tag [16];
    logic [DW-1:0] ref_d   [16];
    logic [DW-1:0] mem_ref [logic [15:0]];
    int unsigned   hit_ref;
    int unsigned   miss_ref;
    logic          pend_w;
    logic [AW-1:0] pend_a;
    logic [DW-1:0] pend_d;
    logic [AW-1:0] pool [8] = '{16'h0124, 16'h0134, 16'h0200, 16'h0005,
                                16'h1005, 16'h00A7, 16'h0F27, 16'h0210};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef CACHE_CTRL_STATS_EN
    cache_refill_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STATS_WIDTH(SW)) dut (
`else
    cache_refill_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
`endif
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_ready (cpu_req_ready),
        .cpu_req_we    (cpu_req_we),
        .cpu_req_addr  (cpu_req_addr),
        .cpu_req_wdata (cpu_req_wdata),
        .cpu_resp_valid(cpu_resp_valid),
        .cpu_resp_rdata(cpu_resp_rdata),
        .cache_addr    (cache_addr),
        .cache_wdata   (cache_wdata),
        .cache_write   (cache_write),
        .cache_rdata   (cache_rdata),
        .cache_hit     (cache_hit),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata)
`ifdef CACHE_CTRL_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        if (mem_ref.exists(a)) return mem_ref[a];
        return {a, ~a};
    endfunction

    function automatic int unsigned sat_inc(input int unsigned v);
`ifdef CACHE_CTRL_STATS_EN
        if (v == (1 << SW) - 1) return v;
`endif
        return v + 1;
    endfunction

    // Advance one clock; apply last cycle's cache write, then present the cache lookup.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (pend_w) begin
            emu_v[pend_a[3:0]]   = 1'b1;
            emu_tag[pend_a[3:0]] = pend_a[15:4];
            emu_d[pend_a[3:0]]   = pend_d;
        end
        pend_w      = cache_write;
        pend_a      = cache_addr;
        pend_d      = cache_wdata;
        cache_hit   = emu_v[cache_addr[3:0]] && (emu_tag[cache_addr[3:0]] == cache_addr[15:4]);
        cache_rdata = emu_d[cache_addr[3:0]];
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ready"}, 64'(cpu_req_ready), 64'(1'b1));
        chk({tag, "_resp"}, 64'(cpu_resp_valid), 64'(1'b0));
        chk({tag, "_mreq"}, 64'(mem_req), 64'(1'b0));
        chk({tag, "_cwr"}, 64'(cache_write), 64'(1'b0));
    endtask

    // One CPU transaction; d = cycles of mem_req before ack. Model timeline is relative to the accept edge.
    task automatic do_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input int d, input logic hold, input logic [AW-1:0] naddr,
                          input logic stray);
        logic [3:0]    idx;
        logic          hit;
        logic [DW-1:0] exp_rd;
        logic [DW-1:0] cw_d;
        int            resp_n;
        int            req_hi;
        int            cw_n;
        idx = addr[3:0];
        chk("ready_at_start", 64'(cpu_req_ready), 64'(1'b1));
        cpu_req_valid = 1'b1;
        cpu_req_we    = we;
        cpu_req_addr  = addr;
        cpu_req_wdata = wd;
        hit  = !we && ref_v[idx] && (ref_tag[idx] == addr[15:4]);
        cw_d = '0;
        if (we) begin
            resp_n = 2 + d; req_hi = 1 + d; cw_n = 0; cw_d = wd; exp_rd = '0;
        end else if (hit) begin
            resp_n = 1; req_hi = 0; cw_n = -1; exp_rd = ref_d[idx];
        end else begin
            resp_n = 3 + d; req_hi = 1 + d; cw_n = 2 + d; cw_d = mem_val(addr); exp_rd = cw_d;
        end
        cycle();
        if (hold) begin
            cpu_req_we    = 1'b0;
            cpu_req_addr  = naddr;
            cpu_req_wdata = $urandom;
        end else begin
            cpu_req_valid = 1'b0;
        end
        for (int n = 0; n <= resp_n + 1; n++) begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (n == req_hi && req_hi >= 1) begin
                mem_ack = 1'b1;
                if (!we) mem_rdata = cw_d;
            end else if (stray && (n == 0 || n == resp_n)) begin
                mem_ack = 1'b1;
            end
            chk("resp_valid", 64'(cpu_resp_valid), 64'(n == resp_n));
            if (n == resp_n) chk("resp_rdata", 64'(cpu_resp_rdata), 64'(exp_rd));
            chk("mem_req", 64'(mem_req), 64'(n >= 1 && n <= req_hi));
            if (n >= 1 && n <= req_hi) begin
                chk("mem_we", 64'(mem_we), 64'(we));
                chk("mem_addr", 64'(mem_addr), 64'(addr));
                if (we) chk("mem_wdata", 64'(mem_wdata), 64'(wd));
            end
            chk("cache_write", 64'(cache_write), 64'(n == cw_n));
            if (n == cw_n) chk("cache_wdata", 64'(cache_wdata), 64'(cw_d));
            chk("cache_addr", 64'(cache_addr), 64'(addr));
            chk("ready_busy", 64'(cpu_req_ready), 64'(n == resp_n + 1));
            if (n <= resp_n) cycle();
        end
        mem_ack = 1'b0;
        if (we || !hit) begin
            ref_v[idx]   = 1'b1;
            ref_tag[idx] = addr[15:4];
            ref_d[idx]   = we ? wd : cw_d;
        end
        if (we) mem_ref[addr] = wd;
        if (!we) begin
            if (hit) hit_ref = sat_inc(hit_ref);
            else     miss_ref = sat_inc(miss_ref);
        end
`ifdef CACHE_CTRL_STATS_EN
        chk("hit_count", 64'(hit_count), 64'(hit_ref));
        chk("miss_count", 64'(miss_count), 64'(miss_ref));
`endif
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            emu_v[i] = 1'b0; emu_tag[i] = '0; emu_d[i] = '0;
            ref_v[i] = 1'b0; ref_tag[i] = '0; ref_d[i] = '0;
        end
        hit_ref = 0; miss_ref = 0;
        pend_w = 1'b0; pend_a = '0; pend_d = '0;
        rst_n = 1'b0;
        cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
        cache_hit = 1'b0; cache_rdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) cycle();

        // Reset state
        check_idle("rst");
        chk("rst_rdata", 64'(cpu_resp_rdata), 64'(0));
        chk("rst_caddr", 64'(cache_addr), 64'(0));
        chk("rst_cwdata", 64'(cache_wdata), 64'(0));
        chk("rst_mwe", 64'(mem_we), 64'(0));
        chk("rst_maddr", 64'(mem_addr), 64'(0));
        chk("rst_mwdata", 64'(mem_wdata), 64'(0));
`ifdef CACHE_CTRL_STATS_EN
        chk("rst_hits", 64'(hit_count), 64'(0));
        chk("rst_misses", 64'(miss_count), 64'(0));
`endif
        rst_n = 1'b1;
        cycle();

        // Read miss, fill, then hit on the same address
        mem_ref[16'h0124] = 32'hDEADBEEF;
        do_txn(1'b0, 16'h0124, '0, 3, 1'b0, '0, 1'b0);
        do_txn(1'b0, 16'h0124, '0, 0, 1'b0, '0, 1'b0);

        // Write with ack in the first mem_req cycle
        do_txn(1'b1, 16'h0200, 32'h12345678, 0, 1'b0, '0, 1'b0);

        // Request held during a conflicting miss, then accepted only afterwards
        do_txn(1'b0, 16'h0134, '0, 2, 1'b1, 16'h0200, 1'b1);
        do_txn(1'b0, 16'h0200, '0, 0, 1'b0, '0, 1'b0);

        // Stray ack in IDLE
        mem_ack = 1'b1;
        cycle();
        mem_ack = 1'b0;
        check_idle("stray0");
        cycle();
        check_idle("stray1");

        // Reset in MEM_RD: no response, later ack ignored
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 16'h0005;
        cycle();
        cpu_req_valid = 1'b0;
        cycle();
        chk("rstrd_mreq", 64'(mem_req), 64'(1'b1));
        rst_n = 1'b0;
        cycle();
        check_idle("rstrd_now");
        hit_ref = 0; miss_ref = 0;
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        cycle();
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_idle("rstrd_after");
            cycle();
        end

        // Repeated read hits (saturate small counters), then mixed writes
        for (int i = 0; i < 5; i++) do_txn(1'b0, 16'h0200, '0, 0, 1'b0, '0, 1'b0);
        do_txn(1'b1, 16'h0210, 32'hCAFE0001, 1, 1'b0, '0, 1'b0);

        // Randomized traffic over a small conflicting address pool
        for (int i = 0; i < 40; i++) begin
            logic [AW-1:0] a;
            a = pool[$urandom_range(0, 7)];
            do_txn(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 4)),
                   1'b0, '0, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
